// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and FSM encoding for the pipeline controller
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // stall[5:0] = {wb, mem, ex, id, if, pc}
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INST    = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MADD2    = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_div_watchdog.sv
// rtl/pipe_ctrl_div_watchdog.sv - divide cycle counter, timeout compare and sticky error flag
module div_watchdog #(
  parameter int DIV_MAX_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  input  logic fire,
  output logic timeout,
  output logic err
);

  logic [CNT_W-1:0] cnt;

  // Saturating counter: a stuck divider must never wrap back under the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (fire) begin
      err <= 1'b1;
    end
  end

  assign timeout = (cnt == CNT_W'(DIV_MAX_CYCLES));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush controller with MADD and divide sequencing for the 5-stage core
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int          DIV_MAX_CYCLES = 40,
  parameter int          CNT_W          = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        ex_madd_i,
  input  logic        ex_div_i,
  input  logic        div_ready_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        madd_phase_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_err_o
);

  state_t state, state_next;
  logic   ex_req;
  logic   wd_clear, wd_count, wd_fire, wd_timeout, wd_err;

  div_watchdog #(
    .DIV_MAX_CYCLES(DIV_MAX_CYCLES),
    .CNT_W         (CNT_W)
  ) u_div_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .count  (wd_count),
    .fire   (wd_fire),
    .timeout(wd_timeout),
    .err    (wd_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    ex_req       = NO_STOP;
    stall        = STALL_NONE;
    flush        = 1'b0;
    new_pc       = 32'h0000_0000;
    madd_phase_o = 1'b0;
    div_start_o  = 1'b0;
    div_annul_o  = 1'b0;
    wd_clear     = 1'b0;
    wd_count     = 1'b0;
    wd_fire      = 1'b0;

    if (rst) begin
      state_next = IDLE;
      wd_clear   = 1'b1;
    end else if (excepttype_i != EXC_NONE) begin
      // Exceptions override everything; an in-flight divide must be aborted.
      flush       = 1'b1;
      new_pc      = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
      state_next  = IDLE;
      wd_clear    = 1'b1;
      div_annul_o = (state == DIV_WAIT);
    end else begin
      unique case (state)
        IDLE: begin
          if (ex_madd_i) begin
            ex_req     = STOP;
            state_next = MADD2;
          end else if (ex_div_i) begin
            ex_req      = STOP;
            div_start_o = 1'b1;
            wd_clear    = 1'b1;
            state_next  = DIV_WAIT;
          end
        end
        MADD2: begin
          madd_phase_o = 1'b1;
          state_next   = IDLE;
        end
        DIV_WAIT: begin
          if (div_ready_i) begin
            state_next = IDLE;
          end else if (wd_timeout) begin
            div_annul_o = 1'b1;
            wd_fire     = 1'b1;
            state_next  = IDLE;
          end else begin
            ex_req      = STOP;
            div_start_o = 1'b1;
            wd_count    = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase

      if (ex_req == STOP) begin
        stall = STALL_EX;
      end else if (stallreq_id_i) begin
        stall = STALL_ID;
      end
    end
  end

  assign div_err_o = wd_err & ~rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i;
  logic        ex_madd_i;
  logic        ex_div_i;
  logic        div_ready_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        madd_phase_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id_i(stallreq_id_i),
    .ex_madd_i    (ex_madd_i),
    .ex_div_i     (ex_div_i),
    .div_ready_i  (div_ready_i),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .madd_phase_o (madd_phase_o),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_err_o    (div_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1; stallreq_id_i = 1'b0; ex_madd_i = 1'b0; ex_div_i = 1'b1;
    div_ready_i = 1'b0; excepttype_i = 32'h0; cp0_epc_i = 32'h0;
    settle();
    check("rst_stall", 32'(stall), 32'h00);
    check("rst_start", 32'(div_start_o), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_err", 32'(div_err_o), 32'h0);
    tick();
    tick();
    rst = 1'b0; ex_div_i = 1'b0;
    settle();
    check("idle_stall", 32'(stall), 32'h00);
    check("idle_err", 32'(div_err_o), 32'h0);
    check("idle_madd_phase", 32'(madd_phase_o), 32'h0);

    // load-use stall from ID only
    tick();
    stallreq_id_i = 1'b1;
    settle();
    check("id_stall", 32'(stall), 32'h07);
    check("id_flush", 32'(flush), 32'h0);
    tick();
    stallreq_id_i = 1'b0;
    settle();
    check("id_release", 32'(stall), 32'h00);

    // MADD: one stall cycle, then second phase
    tick();
    ex_madd_i = 1'b1;
    settle();
    check("madd1_stall", 32'(stall), 32'h0f);
    check("madd1_phase", 32'(madd_phase_o), 32'h0);
    tick();
    settle();
    check("madd2_stall", 32'(stall), 32'h00);
    check("madd2_phase", 32'(madd_phase_o), 32'h1);
    tick();
    ex_madd_i = 1'b0;
    settle();
    check("madd3_phase", 32'(madd_phase_o), 32'h0);
    check("madd3_stall", 32'(stall), 32'h00);

    // divide: 34 stalled cycles, ready on the next one
    tick();
    ex_div_i = 1'b1;
    for (int i = 0; i < 34; i++) begin
      settle();
      check($sformatf("div_stall_%0d", i), 32'(stall), 32'h0f);
      check($sformatf("div_start_%0d", i), 32'(div_start_o), 32'h1);
      tick();
    end
    div_ready_i = 1'b1;
    settle();
    check("div_ready_stall", 32'(stall), 32'h00);
    check("div_ready_start", 32'(div_start_o), 32'h0);
    check("div_ready_annul", 32'(div_annul_o), 32'h0);
    tick();
    ex_div_i = 1'b0; div_ready_i = 1'b0;
    settle();
    check("div_done_err", 32'(div_err_o), 32'h0);
    check("div_done_stall", 32'(stall), 32'h00);

    // exception while waiting on the divider
    tick();
    ex_div_i = 1'b1;
    settle();
    check("dflush_start0", 32'(div_start_o), 32'h1);
    tick();
    settle();
    check("dflush_start1", 32'(div_start_o), 32'h1);
    tick();
    excepttype_i = 32'h0000_000c;
    settle();
    check("dflush_flush", 32'(flush), 32'h1);
    check("dflush_new_pc", new_pc, 32'h0000_0020);
    check("dflush_annul", 32'(div_annul_o), 32'h1);
    check("dflush_stall", 32'(stall), 32'h00);
    check("dflush_start", 32'(div_start_o), 32'h0);
    tick();
    excepttype_i = 32'h0; ex_div_i = 1'b0;
    settle();
    check("dflush_idle_start", 32'(div_start_o), 32'h0);
    check("dflush_idle_flush", 32'(flush), 32'h0);
    check("dflush_idle_annul", 32'(div_annul_o), 32'h0);

    // ERET from IDLE beats a pending divide and ID stall
    tick();
    excepttype_i = 32'h0000_000e; cp0_epc_i = 32'h0000_1234;
    ex_div_i = 1'b1; stallreq_id_i = 1'b1;
    settle();
    check("eret_flush", 32'(flush), 32'h1);
    check("eret_new_pc", new_pc, 32'h0000_1234);
    check("eret_stall", 32'(stall), 32'h00);
    check("eret_start", 32'(div_start_o), 32'h0);
    check("eret_annul", 32'(div_annul_o), 32'h0);
    tick();
    excepttype_i = 32'h0; ex_div_i = 1'b0; stallreq_id_i = 1'b0;
    settle();
    check("eret_after_start", 32'(div_start_o), 32'h0);

    // EX request overrides ID request; ID request honoured in MADD2
    tick();
    ex_madd_i = 1'b1; stallreq_id_i = 1'b1;
    settle();
    check("prio_ex_over_id", 32'(stall), 32'h0f);
    tick();
    ex_madd_i = 1'b0;
    settle();
    check("madd2_id_stall", 32'(stall), 32'h07);
    check("madd2_id_phase", 32'(madd_phase_o), 32'h1);
    tick();
    stallreq_id_i = 1'b0;

    // divide that never completes: 41 stalled cycles, then watchdog
    ex_div_i = 1'b1;
    for (int i = 0; i < 41; i++) begin
      settle();
      check($sformatf("wd_stall_%0d", i), 32'(stall), 32'h0f);
      check($sformatf("wd_annul_%0d", i), 32'(div_annul_o), 32'h0);
      tick();
    end
    settle();
    check("wd_fire_annul", 32'(div_annul_o), 32'h1);
    check("wd_fire_start", 32'(div_start_o), 32'h0);
    check("wd_fire_stall", 32'(stall), 32'h00);
    check("wd_fire_err_pre", 32'(div_err_o), 32'h0);
    tick();
    ex_div_i = 1'b0;
    settle();
    check("wd_err_set", 32'(div_err_o), 32'h1);
    check("wd_after_annul", 32'(div_annul_o), 32'h0);
    tick();
    tick();
    settle();
    check("wd_err_sticky", 32'(div_err_o), 32'h1);
    tick();
    rst = 1'b1;
    settle();
    check("wd_err_rst", 32'(div_err_o), 32'h0);
    tick();
    rst = 1'b0;
    settle();
    check("wd_err_cleared", 32'(div_err_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
